// File: rtl/colour_pkg.sv
// Shared types and helpers for the colour palette: default entry table and
// per-channel brightness shift, written for any channel width up to MAX_CH_W.
package colour_pkg;

  localparam int CH_W_DEF  = 8;
  localparam int IDX_W_DEF = 3;
  localparam int MAX_CH_W  = 16;
  localparam int MAX_RGB_W = 3 * MAX_CH_W;

  typedef logic [1:0]           dim_t;
  typedef logic [MAX_RGB_W-1:0] wide_rgb_t;

  function automatic wide_rgb_t chan_ones(input int ch_w);
    wide_rgb_t m;
    m = '0;
    for (int b = 0; b < MAX_CH_W; b++) begin
      if (b < ch_w) m[b] = 1'b1;
    end
    return m;
  endfunction

  // Index bits {2,1,0} select {R,G,B} at full scale; entries 8 and up are black.
  function automatic wide_rgb_t default_colour(input int idx, input int ch_w);
    wide_rgb_t ones;
    wide_rgb_t res;
    ones = chan_ones(ch_w);
    res  = '0;
    if (idx >= 0 && idx < 8) begin
      if (idx[2]) res = res | (ones << (2 * ch_w));
      if (idx[1]) res = res | (ones << ch_w);
      if (idx[0]) res = res | ones;
    end
    return res;
  endfunction

  function automatic wide_rgb_t dim_rgb(input wide_rgb_t rgb, input dim_t dim, input int ch_w);
    wide_rgb_t ones;
    wide_rgb_t chan;
    wide_rgb_t res;
    ones = chan_ones(ch_w);
    res  = '0;
    for (int c = 0; c < 3; c++) begin
      chan = (rgb >> (c * ch_w)) & ones;
      res  = res | ((chan >> dim) << (c * ch_w));
    end
    return res;
  endfunction

endpackage

// File: rtl/colour_palette_mem.sv
// Register-file palette: resets to the default table, one write port and a
// write-first combinational read port.
module colour_palette_mem
  import colour_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int CH_W  = CH_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [3*CH_W-1:0]   wr_rgb,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [3*CH_W-1:0]   rd_rgb
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam int RGB_W = 3 * CH_W;

  logic [RGB_W-1:0] pal [DEPTH];

  function automatic logic [RGB_W-1:0] dflt(input int i);
    wide_rgb_t w;
    w = default_colour(i, CH_W);
    return w[RGB_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pal[i] <= dflt(i);
    end else if (wr_en) begin
      pal[wr_idx] <= wr_rgb;
    end
  end

  // Bypass so a same-edge write is what the reader captures.
  assign rd_rgb = (wr_en && (wr_idx == rd_idx)) ? wr_rgb : pal[rd_idx];

endmodule

// File: rtl/colour_palette_lut.sv
// Colour index to packed {R,G,B} lookup: writable palette, two-stage
// valid-tagged read pipeline with stall, and per-pixel dimming.
module colour_palette_lut
  import colour_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int CH_W  = CH_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic [IDX_W-1:0]   in_idx,
  input  logic [1:0]         in_dim,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [3*CH_W-1:0]  wr_rgb,
  output logic               out_valid,
  output logic [3*CH_W-1:0]  out_rgb
);

  localparam int RGB_W = 3 * CH_W;

  logic [RGB_W-1:0] rd_rgb_p0;
  logic             vld_p1;
  logic [RGB_W-1:0] rgb_p1;
  dim_t             dim_p1;

  function automatic logic [RGB_W-1:0] dim_word(input logic [RGB_W-1:0] rgb, input dim_t dim);
    wide_rgb_t w;
    w = dim_rgb(wide_rgb_t'(rgb), dim, CH_W);
    return w[RGB_W-1:0];
  endfunction

  colour_palette_mem #(
    .IDX_W (IDX_W),
    .CH_W  (CH_W)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_idx (wr_idx),
    .wr_rgb (wr_rgb),
    .rd_idx (in_idx),
    .rd_rgb (rd_rgb_p0)
  );

  // Stage 1: capture palette read and request tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      rgb_p1 <= '0;
      dim_p1 <= '0;
    end else if (en) begin
      vld_p1 <= in_valid;
      rgb_p1 <= rd_rgb_p0;
      dim_p1 <= in_dim;
    end
  end

  // Stage 2: dim and present
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_rgb   <= '0;
    end else if (en) begin
      out_valid <= vld_p1;
      out_rgb   <= dim_word(rgb_p1, dim_p1);
    end
  end

endmodule

// File: doc/colour_palette_lut.md
# colour_palette_lut

Parametrised, writable colour palette for the display path: converts a colour index to a packed RGB word through a register-file palette. It adds runtime palette updates, a valid-tagged two-stage read pipeline with stall, and per-pixel brightness dimming. It sits between the pixel/colour-index source and the RGB output stage.

## Interface

Parameters:
- IDX_W, 3, index width; palette depth DEPTH = 2**IDX_W.
- CH_W, 8, bits per colour channel; RGB_W = 3*CH_W, packed as {R,G,B}.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, pipeline advance; 0 freezes the read pipeline.
- in_valid, input, 1, read request qualifier.
- in_idx, input, IDX_W, palette index to look up.
- in_dim, input, 2, brightness shift applied to this request (0 = full, 3 = 1/8).
- wr_en, input, 1, palette write strobe; independent of en.
- wr_idx, input, IDX_W, entry to write.
- wr_rgb, input, RGB_W, new entry value.
- out_valid, output, 1, out_rgb holds a result.
- out_rgb, output, RGB_W, looked-up, dimmed colour.

## Operation

- Palette: DEPTH entries of RGB_W, held in flops.
- Default contents:
  - Entries 0..7 use bit2 = R, bit1 = G, bit0 = B, each channel all-ones when its bit is set: 0 black, 1 blue, 2 green, 3 cyan, 4 red, 5 magenta, 6 yellow, 7 white. With CH_W=8: 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF.
  - Entries 8..DEPTH-1 are zero.
  - If IDX_W < 3, only entries 0..DEPTH-1 of the table are used.
- Write: when wr_en=1, palette[wr_idx] <= wr_rgb at the clock edge. Writes proceed whether en is 0 or 1.
- Stage 1, when en=1: s1_valid <= in_valid, s1_rgb <= palette read of in_idx, s1_dim <= in_dim.
- Write-first read: if wr_en=1 and wr_idx==in_idx at the same edge, s1_rgb captures wr_rgb.
- Stage 2, when en=1: out_valid <= s1_valid, out_rgb <= each channel of s1_rgb logically shifted right by s1_dim. Shifting is per channel, so no bits cross channels.
- en=0: s1_* and out_* hold their values; in_valid is ignored and not queued.
- Data registers load even when the valid bit is 0. Consumers qualify with out_valid only.
- A write to an entry already captured in stage 1 does not alter that in-flight result.

## Timing

- Reset, asynchronous, while rst_n=0:
  - out_valid=0, out_rgb=0, s1_valid=0, s1_rgb=0, s1_dim=0.
  - Palette restored to the default contents.
  - wr_en is ignored.
- Reset mid-operation drops all in-flight requests. The first request accepted after reset release sees the default palette.
- Latency: request sampled at edge N (en=1) appears on out_rgb/out_valid after edge N+1, assuming en=1 at N+1. Each en=0 cycle adds one cycle.
- Throughput: one request per cycle while en=1.
- Write visibility:
  - A write at edge N is seen by a read sampled at edge N (write-first) and by all later reads.
  - A read sampled at edge N-1 gets the old value.
- Back-to-back writes to the same index: last write wins. A read sampled at the same edge returns the value written at that edge.

## Structure

- Package colour_pkg:
  - Default CH_W and IDX_W.
  - dim_t (2-bit type).
  - Function default_colour(idx, ch_w) returning the default entry.
  - Function dim_rgb(rgb, dim) applying the per-channel shift.
- Sub-module colour_palette_mem holds the register-file palette, reset-to-default, write port and write-first combinational read.
- Top level colour_palette_lut holds the two pipeline stages, en gating and dimming.

## Test plan

- Reset then stream in_idx 0..7 with in_valid=1, en=1, in_dim=0 → two cycles later out_rgb = 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF on consecutive cycles, out_valid=1 throughout.
- wr_en=1, wr_idx=3, wr_rgb=123456 in the same cycle as read of idx 3 → out_rgb=123456. A read of idx 3 sampled one cycle earlier → 00FFFF.
- Read idx 7 with in_dim=1, then 2, then 3 → 7F7F7F, 3F3F3F, 1F1F1F. Read idx 4 with in_dim=1 → 7F0000.
- Request idx 5 then hold en=0 for 3 cycles → out_valid/out_rgb frozen, in_valid pulses during the stall are not output. After en=1, FF00FF emerges in order with no duplicates.
- Write idx 2 = ABCDEF, pulse rst_n low mid-stream → out_valid=0 and out_rgb=0 immediately. After release, read idx 2 → 00FF00 (default restored).
- Parametrise IDX_W=4, CH_W=4. Read idx 7 → FFF, idx 12 → 000. Write idx 15 = 5A3, read it with in_dim=1 → 251.
